// File: rtl/pcomp_table_dma_responder.sv
// PCOMP table DMA responder.
// Serves word bursts out of a host-loaded table RAM over the
// req/ack/addr/len/data/valid/done handshake.
// The inter-beat gap is programmable.
// Every output is a register, so no input reaches an output combinationally.
module pcomp_table_dma_responder #(
  parameter int ADDR_BITS = 10
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic                 wr_en_i,
  input  logic [ADDR_BITS-1:0] wr_addr_i,
  input  logic [31:0]          wr_data_i,
  input  logic [3:0]           GAP,
  input  logic                 abort_i,
  input  logic                 dma_req_i,
  input  logic [31:0]          dma_addr_i,
  input  logic [7:0]           dma_len_i,
  output logic                 dma_ack_o,
  output logic [31:0]          dma_data_o,
  output logic                 dma_valid_o,
  output logic                 dma_done_o,
  output logic                 busy_o,
  output logic                 err_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACK    = 2'd1,
    S_STREAM = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam int DEPTH = 2 ** ADDR_BITS;

  state_t               state_q;
  logic [ADDR_BITS-1:0] ptr_q;        // next word to read
  logic [8:0]           reads_left_q; // reads still to issue
  logic [8:0]           beats_left_q; // beats still to deliver
  logic [3:0]           gap_q;        // GAP captured at ack
  logic [3:0]           gap_cnt_q;    // idle cycles before the next read
  logic                 rd_pend_q;    // ram_q holds a word to deliver
  logic                 ack_q;
  logic                 valid_q;
  logic                 done_q;
  logic                 busy_q;
  logic                 err_q;
  logic [31:0]          data_q;

  logic [31:0]          mem_q [DEPTH];
  logic [31:0]          ram_q;

  logic                 rd_en_d;
  logic [ADDR_BITS-1:0] rd_addr_d;
  logic [ADDR_BITS-1:0] start_ptr_d;
  logic [8:0]           len_d;
  logic                 range_err_d;
  logic                 unused_addr_bits;

  // Byte-offset bits of the start address carry no information.
  assign unused_addr_bits = ^dma_addr_i[1:0];

  assign start_ptr_d = dma_addr_i[ADDR_BITS+1:2];
  assign len_d       = (dma_len_i == 8'd0) ? 9'd256 : {1'b0, dma_len_i};
  assign range_err_d = |dma_addr_i[31:ADDR_BITS+2];

  // Select the RAM read address; the start address is used directly in ACK so the first word returns a cycle earlier.
  always_comb begin
    rd_en_d   = 1'b0;
    rd_addr_d = ptr_q;
    case (state_q)
      S_ACK: begin
        rd_en_d   = 1'b1;
        rd_addr_d = start_ptr_d;
      end
      S_STREAM: begin
        if (!abort_i && (reads_left_q != 9'd0) && (gap_cnt_q == 4'd0)) begin
          rd_en_d = 1'b1;
        end else begin
          rd_en_d = 1'b0;
        end
      end
      default: begin
        rd_en_d = 1'b0;
      end
    endcase
  end

  // Table RAM: one write port and one read-first synchronous read port, so a same-cycle write returns the old word.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    if (rd_en_d) begin
      ram_q <= mem_q[rd_addr_d];
    end
  end

  // Burst FSM with registered handshake outputs.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      reads_left_q <= 9'd0;
      beats_left_q <= 9'd0;
      gap_q        <= 4'd0;
      gap_cnt_q    <= 4'd0;
      rd_pend_q    <= 1'b0;
      ack_q        <= 1'b0;
      valid_q      <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      data_q       <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          valid_q <= 1'b0;
          done_q  <= 1'b0;
          if (dma_req_i) begin
            state_q <= S_ACK;
            ack_q   <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        S_ACK: begin
          ack_q        <= 1'b0;
          ptr_q        <= start_ptr_d + 1'b1;
          beats_left_q <= len_d;
          reads_left_q <= len_d - 9'd1;
          gap_q        <= GAP;
          gap_cnt_q    <= GAP;
          if (range_err_d) begin
            err_q <= 1'b1;
          end
          if (abort_i) begin
            rd_pend_q <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= S_DONE;
          end else begin
            rd_pend_q <= 1'b1;
            state_q   <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (abort_i) begin
            // The beat already on the bus this cycle stands; anything in flight is dropped.
            valid_q   <= 1'b0;
            rd_pend_q <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= S_DONE;
          end else if (beats_left_q == 9'd0) begin
            valid_q <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            if (rd_pend_q) begin
              data_q       <= ram_q;
              valid_q      <= 1'b1;
              beats_left_q <= beats_left_q - 9'd1;
            end else begin
              valid_q <= 1'b0;
            end
            if (reads_left_q != 9'd0) begin
              if (gap_cnt_q == 4'd0) begin
                ptr_q        <= ptr_q + 1'b1;
                reads_left_q <= reads_left_q - 9'd1;
                rd_pend_q    <= 1'b1;
                gap_cnt_q    <= gap_q;
              end else begin
                gap_cnt_q <= gap_cnt_q - 4'd1;
                rd_pend_q <= 1'b0;
              end
            end else begin
              rd_pend_q <= 1'b0;
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign dma_ack_o   = ack_q;
  assign dma_data_o  = data_q;
  assign dma_valid_o = valid_q;
  assign dma_done_o  = done_q;
  assign busy_o      = busy_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_pcomp_table_dma_responder.sv
// Directed testbench for pcomp_table_dma_responder.
// Inputs are driven on the falling edge, and outputs are sampled there too.
module tb_pcomp_table_dma_responder;

  localparam int AB = 10;

  logic          clk;
  logic          reset_n;
  logic          wr_en;
  logic [AB-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic [3:0]    gap_s;
  logic          abort_s;
  logic          req;
  logic [31:0]   addr;
  logic [7:0]    len;
  logic          ack;
  logic [31:0]   data;
  logic          valid;
  logic          done;
  logic          busy;
  logic          err;

  int n_cmp = 0;
  int n_bad = 0;

  // Captured burst observations; offsets are falling-edge indices after the request was raised.
  int          ack_n, ack2_n, done_n, n_done, n_valid, extra_valid, busy_cnt;
  logic        err_at_ack, err_after_ack, busy_after_done;
  int          valid_off [0:299];
  logic [31:0] valid_dat [0:299];

  pcomp_table_dma_responder #(.ADDR_BITS(AB)) dut (
    .clk_i       (clk),
    .reset_n_i   (reset_n),
    .wr_en_i     (wr_en),
    .wr_addr_i   (wr_addr),
    .wr_data_i   (wr_data),
    .GAP         (gap_s),
    .abort_i     (abort_s),
    .dma_req_i   (req),
    .dma_addr_i  (addr),
    .dma_len_i   (len),
    .dma_ack_o   (ack),
    .dma_data_o  (data),
    .dma_valid_o (valid),
    .dma_done_o  (done),
    .busy_o      (busy),
    .err_o       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic write_word(input logic [AB-1:0] a, input logic [31:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Raise a request and record ack/valid/done/busy activity.
  // abort_beat != 0 raises abort_i alongside that beat.
  // With hold set, req stays high until a second ack is seen.
  task automatic capture(input logic [31:0] a, input logic [7:0] l, input logic [3:0] g,
                         input int abort_beat, input bit hold, input int budget);
    ack_n = -1; ack2_n = -1; done_n = -1; n_done = 0; n_valid = 0; extra_valid = 0;
    busy_cnt = 0; err_at_ack = 1'bx; err_after_ack = 1'bx; busy_after_done = 1'bx;
    @(negedge clk);
    req = 1'b1; addr = a; len = l; gap_s = g;
    for (int n = 1; n <= budget; n++) begin
      @(negedge clk);
      abort_s = 1'b0;
      if (ack) begin
        if (ack_n < 0) begin
          ack_n = n; err_at_ack = err;
          if (!hold) req = 1'b0;
        end else if (ack2_n < 0 && done_n >= 0) begin
          ack2_n = n; req = 1'b0;
        end
      end
      if (ack_n >= 0 && n == ack_n + 1) err_after_ack = err;
      if (done_n >= 0 && n == done_n + 1) busy_after_done = busy;
      if (done_n < 0) begin
        if (busy) busy_cnt++;
        if (valid) begin
          if (n_valid < 300) begin
            valid_off[n_valid] = n - ack_n;
            valid_dat[n_valid] = data;
          end
          n_valid++;
          if (abort_beat != 0 && n_valid == abort_beat) abort_s = 1'b1;
        end
      end else if (valid) begin
        extra_valid++;
      end
      if (done) begin
        n_done++;
        if (done_n < 0) done_n = n;
      end
      if (done_n >= 0 && n >= done_n + 4 && (!hold || ack2_n >= 0)) break;
    end
    req = 1'b0; abort_s = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({ack, valid, done, busy, err, data} !== 37'd0) begin
      n_bad++; $display("FAIL reset_outputs: got %b expected all zero", {ack, valid, done, busy, err, data});
    end
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [31:0] exp_d;
    for (int i = 0; i < 8; i++) write_word(AB'(i), 32'h1000 + 32'(i));
    capture(32'h0, 8'd4, 4'd0, 0, 1'b0, 30);
    n_cmp++;
    if (ack_n !== 1) begin n_bad++; $display("FAIL basic_ack: got %0d expected 1", ack_n); end
    n_cmp++;
    if (n_valid !== 4) begin n_bad++; $display("FAIL basic_nvalid: got %0d expected 4", n_valid); end
    for (int i = 0; i < 4 && i < n_valid; i++) begin
      exp_d = 32'h1000 + 32'(i);
      n_cmp++;
      if (valid_off[i] !== 2 + i || valid_dat[i] !== exp_d) begin
        n_bad++; $display("FAIL basic_beat%0d: got off %0d data %h expected off %0d data %h", i, valid_off[i], valid_dat[i], 2 + i, exp_d);
      end
    end
    n_cmp++;
    if (done_n - ack_n !== 6 || n_done !== 1) begin
      n_bad++; $display("FAIL basic_done: got off %0d count %0d expected off 6 count 1", done_n - ack_n, n_done);
    end
    n_cmp++;
    if (busy_cnt !== 7 || busy_after_done !== 1'b0) begin
      n_bad++; $display("FAIL basic_busy: got %0d cycles after=%b expected 7 cycles after=0", busy_cnt, busy_after_done);
    end
    n_cmp++;
    if (err !== 1'b0) begin n_bad++; $display("FAIL basic_err: got %b expected 0", err); end
  endtask

  task automatic test_wrap_gap();
    logic [31:0] exp_d [0:3];
    int          exp_o [0:3];
    exp_d[0] = 32'hA3FE; exp_d[1] = 32'hA3FF; exp_d[2] = 32'h1000; exp_d[3] = 32'h1001;
    exp_o[0] = 2; exp_o[1] = 5; exp_o[2] = 8; exp_o[3] = 11;
    write_word(AB'(1022), 32'hA3FE);
    write_word(AB'(1023), 32'hA3FF);
    capture(32'h0000_0FF8, 8'd4, 4'd2, 0, 1'b0, 40);
    n_cmp++;
    if (n_valid !== 4) begin n_bad++; $display("FAIL wrap_nvalid: got %0d expected 4", n_valid); end
    for (int i = 0; i < 4 && i < n_valid; i++) begin
      n_cmp++;
      if (valid_off[i] !== exp_o[i] || valid_dat[i] !== exp_d[i]) begin
        n_bad++; $display("FAIL wrap_beat%0d: got off %0d data %h expected off %0d data %h", i, valid_off[i], valid_dat[i], exp_o[i], exp_d[i]);
      end
    end
    n_cmp++;
    if (done_n - ack_n !== 12 || err !== 1'b0) begin
      n_bad++; $display("FAIL wrap_done_err: got off %0d err %b expected off 12 err 0", done_n - ack_n, err);
    end
  endtask

  task automatic test_len256_back_to_back();
    capture(32'h0, 8'd0, 4'd0, 0, 1'b1, 320);
    n_cmp++;
    if (n_valid !== 256 || n_done !== 1) begin
      n_bad++; $display("FAIL len256_count: got %0d beats %0d dones expected 256 beats 1 done", n_valid, n_done);
    end
    n_cmp++;
    if (done_n - ack_n !== 258) begin
      n_bad++; $display("FAIL len256_done: got off %0d expected 258", done_n - ack_n);
    end
    n_cmp++;
    if (ack2_n < 0 || ack2_n - done_n !== 2) begin
      n_bad++; $display("FAIL b2b_ack: got %0d cycles after done expected 2", ack2_n - done_n);
    end
    for (int n = 0; n < 300 && busy; n++) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b_drain: got busy %b expected 0", busy); end
  endtask

  task automatic test_addr_error();
    capture(32'h0000_1000, 8'd1, 4'd0, 0, 1'b0, 20);
    n_cmp++;
    if (err_at_ack !== 1'b0 || err_after_ack !== 1'b1) begin
      n_bad++; $display("FAIL err_timing: got ack %b ack+1 %b expected 0 1", err_at_ack, err_after_ack);
    end
    n_cmp++;
    if (n_valid !== 1 || valid_dat[0] !== 32'h1000) begin
      n_bad++; $display("FAIL err_data: got %0d beats data %h expected 1 beat data 00001000", n_valid, valid_dat[0]);
    end
    n_cmp++;
    if (err !== 1'b1 || n_done !== 1) begin
      n_bad++; $display("FAIL err_sticky: got err %b dones %0d expected 1 1", err, n_done);
    end
  endtask

  task automatic test_abort();
    capture(32'h0, 8'd10, 4'd0, 3, 1'b0, 30);
    n_cmp++;
    if (n_valid !== 3 || extra_valid !== 0) begin
      n_bad++; $display("FAIL abort_beats: got %0d plus %0d late expected 3 plus 0", n_valid, extra_valid);
    end
    n_cmp++;
    if (valid_dat[2] !== 32'h1002 || done_n - ack_n !== 5 || n_done !== 1) begin
      n_bad++; $display("FAIL abort_done: got data %h off %0d dones %0d expected 00001002 5 1", valid_dat[2], done_n - ack_n, n_done);
    end
    n_cmp++;
    if (busy_after_done !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b expected 0", busy_after_done); end
  endtask

  task automatic test_async_reset();
    int dones;
    dones = 0;
    @(negedge clk);
    req = 1'b1; addr = 32'h0; len = 8'd8; gap_s = 4'd3;
    @(negedge clk);
    req = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1 || data !== 32'h1000) begin
      n_bad++; $display("FAIL arst_pre: got busy %b data %h expected 1 00001000", busy, data);
    end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({ack, valid, done, busy, err, data} !== 37'd0) begin
      n_bad++; $display("FAIL arst_outputs: got %b expected all zero", {ack, valid, done, busy, err, data});
    end
    repeat (3) begin
      @(negedge clk);
      if (done) dones++;
    end
    reset_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done) dones++;
    end
    n_cmp++;
    if (dones !== 0) begin n_bad++; $display("FAIL arst_no_done: got %0d expected 0", dones); end
    capture(32'h0000_0010, 8'd2, 4'd0, 0, 1'b0, 20);
    n_cmp++;
    if (ack_n !== 1 || n_valid !== 2 || valid_dat[0] !== 32'h1004 || valid_dat[1] !== 32'h1005) begin
      n_bad++; $display("FAIL arst_resume: got ack %0d beats %0d data %h %h expected 1 2 00001004 00001005", ack_n, n_valid, valid_dat[0], valid_dat[1]);
    end
  endtask

  initial begin
    reset_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = 32'd0; gap_s = 4'd0;
    abort_s = 1'b0; req = 1'b0; addr = 32'd0; len = 8'd0;
    test_reset();
    test_basic();
    test_wrap_gap();
    test_len256_back_to_back();
    test_addr_error();
    test_abort();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
